e203_dtcm_ram_arbt: RTL and testbench
=====================================

# e203_dtcm_ram_arbt

Two-requester arbiter and power sequencer in front of the DTCM SRAM macro wrapper. Shares one single-port RAM between requester 0 (LSU) and requester 1 (external ICB slave) with valid/ready handshakes. It holds each read result until the requester accepts it, and drives the RAM light-sleep pin after a programmable idle period.

## Interface
Parameters:
- AW, 13, RAM word-address width
- DW, 64, data width
- MW, 8, byte-mask width (DW/8)
- IDLE_CYC, 16, idle cycles before light sleep; 0 disables sleep

Ports (per requester i in {0,1}):
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ri_cmd_valid  in  1  command valid
- ri_cmd_ready  out  1  command accepted
- ri_cmd_read  in  1  1=read, 0=write
- ri_cmd_addr  in  AW  word address
- ri_cmd_wdata  in  DW  write data
- ri_cmd_wmask  in  MW  byte enables
- ri_rsp_valid  out  1  response valid
- ri_rsp_ready  in  1  response accepted
- ri_rsp_rdata  out  DW  read data; 0 for writes
- ram_cs, ram_we  out  1  RAM chip select, write enable
- ram_addr  out  AW
- ram_wem  out  MW
- ram_din  out  DW
- ram_dout  in  DW  valid the cycle after ram_cs
- ram_sd, ram_ds, ram_ls  out  1  power pins; sd/ds tied 0

## Operation
- Eligibility: elig_i = ri_cmd_valid & (~pend_i | rsp_hs_i), where rsp_hs_i = ri_rsp_valid & ri_rsp_ready.
- Each port has at most one outstanding response.
- Grant only in state ACTIVE.
  - One eligible port: that port wins.
  - Both eligible: arbitration policy decides (see Configuration).
- ri_cmd_ready = grant_i. On handshake:
  - ram_cs=1, ram_we=~read.
  - ram_addr, ram_wem, ram_din driven combinationally from the winner.
  - ram_wem forced 0 on reads.
- Response:
  - Cycle after the access: ri_rsp_valid=1 and pend_i=1.
  - Read rdata in that first cycle comes from ram_dout (bypass) and is also captured into a per-port hold register.
  - In later cycles rdata comes from the hold register, so it stays stable if the other port reuses the RAM.
  - Write rsp_rdata=0.
- ri_rsp_valid stays high until rsp_hs_i. A new command from the same port may be granted in the same cycle as its rsp_hs.
- Power FSM:
  - ACTIVE: idle counter increments each cycle with no ram_cs and no pend. It clears on any cs or pend. At count == IDLE_CYC-1 (and IDLE_CYC≠0), go to SLEEP.
  - SLEEP: ram_ls=1, no grants. Any ri_cmd_valid → WAKE.
  - WAKE: ram_ls=0, no grants. Next cycle → ACTIVE with counter 0.
- Reset (any time): state ACTIVE, counter 0, pend cleared, hold registers 0, RR pointer favours port 0. In-flight responses are dropped.

## Timing
- Reset value of every output is 0.
- Read latency: command handshake in cycle N, rsp_valid and data in N+1.
- Throughput: one access per cycle total.
- Wake penalty: a command arriving in SLEEP is granted 2 cycles later (SLEEP→WAKE→ACTIVE).
- No combinational path from ram_dout to any ready. cmd_ready depends on rsp_ready (documented; requesters must not make rsp_ready depend on cmd_ready).
- Boundaries:
  - Both ports requesting at the same time as the wake transition: no grant until ACTIVE.
  - A port with a pending, unaccepted response is never granted.
  - Counter saturates; no wrap.

## Configuration
- E203_DTCM_ARBT_RR_EN defined: round-robin. The pointer toggles to the non-winner after each grant when both were eligible.
- Undefined: fixed priority, port 0 always wins. The pointer register is removed.

## Structure
- Shared package e203_dtcm_arbt_pkg holds:
  - power-state enum (ACTIVE, SLEEP, WAKE)
  - port index constants
  - default IDLE_CYC localparam
- One sub-module, e203_dtcm_arbt_rsp: per-port response tracker (pend flag, hold register, bypass mux). Instantiated twice.

## Test plan
- Single read: port 0 writes 0x1122334455667788 to addr 5 with mask 0xFF, then reads addr 5 → rsp_valid one cycle later with that data.
- Contention: both ports issue reads every cycle with rsp_ready=1.
  - With RR: grants alternate 0,1,0,1.
  - Without RR: port 0 wins every cycle.
- Backpressure: port 1 reads addr 3 with rsp_ready=0 for 5 cycles while port 0 writes addr 3 → port 1 rdata stays at the old value and its cmd_ready=0 until accepted.
- Byte mask: write 0xFFFF… with mask 0x0F over a zero word → reads back 0x00000000FFFFFFFF.
- Sleep: IDLE_CYC=4, no traffic → ram_ls rises after 4 idle cycles. A read request → ram_ls drops next cycle, grant 2 cycles after the request.
- Reset mid-operation: assert rst while rsp_valid=1 → all outputs 0 immediately. After release the first request is granted normally.

Source files
------------

// File: rtl/e203_dtcm_ram_arbt_pkg.sv
// Shared types and constants for the DTCM RAM arbiter.
// Optional round-robin arbitration is enabled with E203_DTCM_ARBT_RR_EN.
package e203_dtcm_arbt_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } pwr_state_e;

  localparam int unsigned PORT_LSU     = 0;
  localparam int unsigned PORT_EXT     = 1;
  localparam int unsigned NUM_PORTS    = 2;
  localparam int unsigned DEF_IDLE_CYC = 16;

endpackage

// File: rtl/e203_dtcm_ram_arbt_if.sv
// Requester command/response handshakes plus the SRAM macro pins.
interface e203_dtcm_ram_arbt_if
  import e203_dtcm_arbt_pkg::*;
#(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 64,
  parameter int unsigned MW = 8
);
  logic          r0_cmd_valid, r0_cmd_ready, r0_cmd_read;
  logic [AW-1:0] r0_cmd_addr;
  logic [DW-1:0] r0_cmd_wdata;
  logic [MW-1:0] r0_cmd_wmask;
  logic          r0_rsp_valid, r0_rsp_ready;
  logic [DW-1:0] r0_rsp_rdata;

  logic          r1_cmd_valid, r1_cmd_ready, r1_cmd_read;
  logic [AW-1:0] r1_cmd_addr;
  logic [DW-1:0] r1_cmd_wdata;
  logic [MW-1:0] r1_cmd_wmask;
  logic          r1_rsp_valid, r1_rsp_ready;
  logic [DW-1:0] r1_rsp_rdata;

  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_sd, ram_ds, ram_ls;

  modport slave (
    input  r0_cmd_valid, r0_cmd_read, r0_cmd_addr, r0_cmd_wdata, r0_cmd_wmask, r0_rsp_ready,
    output r0_cmd_ready, r0_rsp_valid, r0_rsp_rdata,
    input  r1_cmd_valid, r1_cmd_read, r1_cmd_addr, r1_cmd_wdata, r1_cmd_wmask, r1_rsp_ready,
    output r1_cmd_ready, r1_rsp_valid, r1_rsp_rdata,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls,
    input  ram_dout
  );

  modport master (
    output r0_cmd_valid, r0_cmd_read, r0_cmd_addr, r0_cmd_wdata, r0_cmd_wmask, r0_rsp_ready,
    input  r0_cmd_ready, r0_rsp_valid, r0_rsp_rdata,
    output r1_cmd_valid, r1_cmd_read, r1_cmd_addr, r1_cmd_wdata, r1_cmd_wmask, r1_rsp_ready,
    input  r1_cmd_ready, r1_rsp_valid, r1_rsp_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls,
    output ram_dout
  );
endinterface

// File: rtl/e203_dtcm_arbt_rsp.sv
// Per-port response tracker: pending flag, read-data hold register and
// the first-cycle bypass from the RAM output.
module e203_dtcm_arbt_rsp
  import e203_dtcm_arbt_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic          acc_read,
  input  logic          rsp_ready,
  input  logic [DW-1:0] ram_dout,
  output logic          pend,
  output logic [DW-1:0] rdata_c
);
  logic          pend_q, first_q, read_q;
  logic [DW-1:0] hold_q;

  // A new access may reload the tracker in the same cycle its old response is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      read_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      first_q <= acc;
      if (acc) begin
        pend_q <= 1'b1;
        read_q <= acc_read;
      end else if (pend_q && rsp_ready) begin
        pend_q <= 1'b0;
      end
      if (first_q && read_q) hold_q <= ram_dout;
    end
  end

  // RAM output is only trustworthy in the cycle right after our own access.
  assign rdata_c = (pend_q && read_q) ? (first_q ? ram_dout : hold_q) : '0;
  assign pend    = pend_q;
endmodule

// File: rtl/e203_dtcm_ram_arbt.sv
// Two-port arbiter and light-sleep sequencer in front of the DTCM SRAM.
// Define E203_DTCM_ARBT_RR_EN for round-robin; otherwise port 0 has fixed priority.
module e203_dtcm_ram_arbt
  import e203_dtcm_arbt_pkg::*;
#(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 64,
  parameter int unsigned MW       = 8,
  parameter int unsigned IDLE_CYC = DEF_IDLE_CYC
) (
  input  logic                clk,
  input  logic                rst,
  e203_dtcm_ram_arbt_if.slave bus
);
  localparam int unsigned CW       = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int unsigned LAST     = (IDLE_CYC == 0) ? 0 : IDLE_CYC - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
  localparam logic        SLEEP_EN = (IDLE_CYC != 0);

  pwr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend0, pend1, hs0, hs1, elig0, elig1, gnt0, gnt1;
  logic          cs_c, we_c, acc_read;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] din_sel;
  logic [MW-1:0] wem_sel;
`ifdef E203_DTCM_ARBT_RR_EN
  logic          ptr_q, ptr_d;
`endif

  assign hs0   = pend0 & bus.r0_rsp_ready;
  assign hs1   = pend1 & bus.r1_rsp_ready;
  assign elig0 = bus.r0_cmd_valid & (~pend0 | hs0);
  assign elig1 = bus.r1_cmd_valid & (~pend1 | hs1);

  // Grants and power sequencing; grants are suppressed while reset is asserted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
`ifdef E203_DTCM_ARBT_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ACTIVE: begin
        if (!rst) begin
          if (elig0 && elig1) begin
`ifdef E203_DTCM_ARBT_RR_EN
            gnt0  = ~ptr_q;
            gnt1  = ptr_q;
            ptr_d = ~ptr_q;
`else
            gnt0  = 1'b1;
`endif
          end else begin
            gnt0 = elig0;
            gnt1 = elig1;
          end
        end
        if (gnt0 || gnt1 || pend0 || pend1) begin
          cnt_d = '0;
        end else if (SLEEP_EN && (cnt_q == CNT_LAST)) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SLEEP: begin
        cnt_d = '0;
        if (bus.r0_cmd_valid || bus.r1_cmd_valid) state_d = WAKE;
      end
      WAKE: begin
        cnt_d   = '0;
        state_d = ACTIVE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef E203_DTCM_ARBT_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  // RAM request is steered from whichever port won this cycle.
  assign cs_c     = gnt0 | gnt1;
  assign acc_read = gnt1 ? bus.r1_cmd_read : bus.r0_cmd_read;
  assign we_c     = cs_c & ~acc_read;
  assign addr_sel = gnt1 ? bus.r1_cmd_addr  : (gnt0 ? bus.r0_cmd_addr  : '0);
  assign din_sel  = gnt1 ? bus.r1_cmd_wdata : (gnt0 ? bus.r0_cmd_wdata : '0);
  assign wem_sel  = gnt1 ? bus.r1_cmd_wmask : bus.r0_cmd_wmask;

  assign bus.r0_cmd_ready = gnt0;
  assign bus.r1_cmd_ready = gnt1;
  assign bus.ram_cs       = cs_c;
  assign bus.ram_we       = we_c;
  assign bus.ram_addr     = addr_sel;
  assign bus.ram_din      = din_sel;
  assign bus.ram_wem      = we_c ? wem_sel : '0;
  assign bus.ram_ls       = (state_q == SLEEP);
  assign bus.ram_sd       = 1'b0;
  assign bus.ram_ds       = 1'b0;
  assign bus.r0_rsp_valid = pend0;
  assign bus.r1_rsp_valid = pend1;

  e203_dtcm_arbt_rsp #(.DW(DW)) u_rsp0 (
    .clk       (clk),
    .rst       (rst),
    .acc       (gnt0),
    .acc_read  (bus.r0_cmd_read),
    .rsp_ready (bus.r0_rsp_ready),
    .ram_dout  (bus.ram_dout),
    .pend      (pend0),
    .rdata_c   (bus.r0_rsp_rdata)
  );

  e203_dtcm_arbt_rsp #(.DW(DW)) u_rsp1 (
    .clk       (clk),
    .rst       (rst),
    .acc       (gnt1),
    .acc_read  (bus.r1_cmd_read),
    .rsp_ready (bus.r1_rsp_ready),
    .ram_dout  (bus.ram_dout),
    .pend      (pend1),
    .rdata_c   (bus.r1_rsp_rdata)
  );
endmodule

// File: tb/tb_e203_dtcm_ram_arbt.sv
// Directed and randomized bench for e203_dtcm_ram_arbt with a RAM model and scoreboard.
module tb_e203_dtcm_ram_arbt;
  localparam int unsigned AW = 13, DW = 64, MW = 8, IDLE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_dtcm_ram_arbt_if #(.AW(AW), .DW(DW), .MW(MW)) dif ();
  e203_dtcm_ram_arbt #(.AW(AW), .DW(DW), .MW(MW), .IDLE_CYC(IDLE)) dut (
    .clk (clk), .rst (rst), .bus (dif)
  );

  logic [63:0] mem  [0:8191];
  logic [63:0] gold [0:8191];
  logic [63:0] q0[$], q1[$];
  logic        rr_next = 1'b0;
  int          n_assert = 0, n_fail = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-port SRAM: registered read data, byte-masked write.
  always @(posedge clk) begin
    if (dif.ram_cs) begin
      if (dif.ram_we) mem[dif.ram_addr] <= merge(mem[dif.ram_addr], dif.ram_din, dif.ram_wem);
      else            dif.ram_dout <= mem[dif.ram_addr];
    end
  end

  always @(posedge rst) begin
    q0.delete();
    q1.delete();
    rr_next = 1'b0;
  end

  // Scoreboard: each accepted command yields exactly one response; reads return the
  // memory image as of the accepting cycle, writes return zero.
  always @(negedge clk) begin
    logic h0, h1, e0, e1;
    if (!rst) begin
      check("rsp_valid0", dif.r0_rsp_valid, q0.size() != 0);
      check("rsp_valid1", dif.r1_rsp_valid, q1.size() != 0);
      if (q0.size() != 0 && dif.r0_rsp_valid) check("rsp_rdata0", dif.r0_rsp_rdata, q0[0]);
      if (q1.size() != 0 && dif.r1_rsp_valid) check("rsp_rdata1", dif.r1_rsp_rdata, q1[0]);
      h0 = dif.r0_rsp_valid & dif.r0_rsp_ready;
      h1 = dif.r1_rsp_valid & dif.r1_rsp_ready;
      e0 = dif.r0_cmd_valid & ((q0.size() == 0) | h0);
      e1 = dif.r1_cmd_valid & ((q1.size() == 0) | h1);
      check("gnt_inelig0", dif.r0_cmd_ready & ~e0, 0);
      check("gnt_inelig1", dif.r1_cmd_ready & ~e1, 0);
      check("one_grant", dif.r0_cmd_ready & dif.r1_cmd_ready, 0);
      if (e0 && e1 && (dif.r0_cmd_ready || dif.r1_cmd_ready)) begin
`ifdef E203_DTCM_ARBT_RR_EN
        check("rr_order", dif.r1_cmd_ready, rr_next);
        rr_next = ~dif.r1_cmd_ready;
`else
        check("fixed_prio", dif.r0_cmd_ready, 1);
`endif
      end
      if (h0) void'(q0.pop_front());
      if (h1) void'(q1.pop_front());
      if (dif.r0_cmd_valid && dif.r0_cmd_ready) begin
        if (dif.r0_cmd_read) q0.push_back(gold[dif.r0_cmd_addr]);
        else begin
          gold[dif.r0_cmd_addr] = merge(gold[dif.r0_cmd_addr], dif.r0_cmd_wdata, dif.r0_cmd_wmask);
          q0.push_back(64'd0);
        end
      end
      if (dif.r1_cmd_valid && dif.r1_cmd_ready) begin
        if (dif.r1_cmd_read) q1.push_back(gold[dif.r1_cmd_addr]);
        else begin
          gold[dif.r1_cmd_addr] = merge(gold[dif.r1_cmd_addr], dif.r1_cmd_wdata, dif.r1_cmd_wmask);
          q1.push_back(64'd0);
        end
      end
    end
  end

  task automatic cmd(input int p, input logic v, input logic rd, input logic [AW-1:0] a,
                     input logic [63:0] wd, input logic [7:0] m);
    if (p == 0) begin
      dif.r0_cmd_valid = v; dif.r0_cmd_read = rd; dif.r0_cmd_addr = a;
      dif.r0_cmd_wdata = wd; dif.r0_cmd_wmask = m;
    end else begin
      dif.r1_cmd_valid = v; dif.r1_cmd_read = rd; dif.r1_cmd_addr = a;
      dif.r1_cmd_wdata = wd; dif.r1_cmd_wmask = m;
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {dif.r0_cmd_ready, dif.r1_cmd_ready, dif.r0_rsp_valid, dif.r1_rsp_valid,
                          dif.ram_cs, dif.ram_we, dif.ram_sd, dif.ram_ds, dif.ram_ls}, 0);
    check({tag, "_bus"}, 64'(dif.ram_addr) | 64'(dif.ram_wem) | dif.ram_din, 0);
    check({tag, "_rdata"}, dif.r0_rsp_rdata | dif.r1_rsp_rdata, 0);
  endtask

  localparam logic [63:0] VAL_A = 64'hA5A5_A5A5_0123_4567;
  localparam logic [63:0] VAL_B = 64'h5A5A_5A5A_89AB_CDEF;

  initial begin
    int stall, max_stall;
    logic got;
    for (int i = 0; i < 8192; i++) begin mem[i] = '0; gold[i] = '0; end
    dif.ram_dout = '0;
    dif.r0_rsp_ready = 1'b1;
    dif.r1_rsp_ready = 1'b1;
    rst = 1'b1;
    // Requests raised during reset must not be granted.
    cmd(0, 1, 1, 5, 0, 0);
    cmd(1, 1, 1, 9, 0, 0);
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read-back on port 0, back to back.
    cmd(0, 1, 0, 5, 64'h1122_3344_5566_7788, 8'hFF);
    cmd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wr_ready", dif.r0_cmd_ready, 1);
    check("wr_ram", {dif.ram_cs, dif.ram_we, 64'(dif.ram_addr), 64'(dif.ram_wem)},
          {1'b1, 1'b1, 64'd5, 64'hFF});
    check("wr_din", dif.ram_din, 64'h1122_3344_5566_7788);
    nxt();
    cmd(0, 1, 1, 5, 0, 8'hFF);
    @(negedge clk);
    check("wr_rsp", {dif.r0_rsp_valid, dif.r0_rsp_rdata}, {1'b1, 64'd0});
    check("rd_regrant", dif.r0_cmd_ready, 1);
    check("rd_ram", {dif.ram_cs, dif.ram_we, 64'(dif.ram_wem)}, {1'b1, 1'b0, 64'd0});
    nxt();
    cmd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rd_rsp", {dif.r0_rsp_valid, dif.r0_rsp_rdata}, {1'b1, 64'h1122_3344_5566_7788});
    nxt();

    // Partial byte mask over a zero word, on port 1.
    cmd(1, 1, 0, 9, '1, 8'h0F);
    @(negedge clk);
    check("bm_wr_ready", dif.r1_cmd_ready, 1);
    nxt();
    cmd(1, 1, 1, 9, 0, 0);
    @(negedge clk);
    check("bm_rd_ready", dif.r1_cmd_ready, 1);
    nxt();
    cmd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("bm_rdata", {dif.r1_rsp_valid, dif.r1_rsp_rdata}, {1'b1, 64'h0000_0000_FFFF_FFFF});
    nxt();

    // Contention: both ports read every cycle.
    cmd(0, 1, 1, 5, 0, 0);
    cmd(1, 1, 1, 9, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef E203_DTCM_ARBT_RR_EN
      check("contention", {dif.r1_cmd_ready, dif.r0_cmd_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
`else
      check("contention", {dif.r1_cmd_ready, dif.r0_cmd_ready}, 2'b01);
`endif
      nxt();
    end
    cmd(0, 0, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    nxt();

    // Backpressure: port 1 holds its read response while port 0 overwrites the word.
    cmd(0, 1, 0, 3, VAL_A, 8'hFF);
    @(negedge clk);
    check("bp_wr_a", dif.r0_cmd_ready, 1);
    nxt();
    cmd(0, 0, 0, 0, 0, 0);
    cmd(1, 1, 1, 3, 0, 0);
    dif.r1_rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_rd_ready", dif.r1_cmd_ready, 1);
    nxt();
    cmd(0, 1, 0, 3, VAL_B, 8'hFF);
    @(negedge clk);
    check("bp_wr_b", {dif.r0_cmd_ready, dif.r1_cmd_ready}, 2'b10);
    check("bp_hold0", {dif.r1_rsp_valid, dif.r1_rsp_rdata}, {1'b1, VAL_A});
    nxt();
    cmd(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", {dif.r1_cmd_ready, dif.r1_rsp_valid, dif.r1_rsp_rdata}, {1'b0, 1'b1, VAL_A});
      nxt();
    end
    dif.r1_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {dif.r1_cmd_ready, dif.r1_rsp_rdata}, {1'b1, VAL_A});
    nxt();
    cmd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("bp_new_data", {dif.r1_rsp_valid, dif.r1_rsp_rdata}, {1'b1, VAL_B});
    nxt();

    // Sleep entry after IDLE idle cycles, then wake on request.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ls_idle", dif.ram_ls, 0);
      nxt();
    end
    @(negedge clk);
    check("ls_enter", dif.ram_ls, 1);
    nxt();
    @(negedge clk);
    check("ls_stay", {dif.ram_ls, dif.ram_cs}, 2'b10);
    nxt();
    cmd(0, 1, 1, 5, 0, 0);
    @(negedge clk);
    check("wake_req", {dif.ram_ls, dif.r1_cmd_ready, dif.r0_cmd_ready}, 3'b100);
    nxt();
    cmd(1, 1, 1, 9, 0, 0);
    @(negedge clk);
    check("wake_cyc", {dif.ram_ls, dif.r1_cmd_ready, dif.r0_cmd_ready}, 3'b000);
    nxt();
    @(negedge clk);
    check("wake_grant", {dif.ram_ls, dif.r1_cmd_ready, dif.r0_cmd_ready}, 3'b001);
    nxt();
    cmd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wake_grant1", dif.r1_cmd_ready, 1);
    nxt();
    cmd(1, 0, 0, 0, 0, 0);

    // Random traffic against the scoreboard.
    stall = 0;
    max_stall = 0;
    for (int c = 0; c < 400; c++) begin
      if (!dif.r0_cmd_valid || dif.r0_cmd_ready)
        cmd(0, $urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom_range(0, 7)),
            {$urandom, $urandom}, 8'($urandom));
      if (!dif.r1_cmd_valid || dif.r1_cmd_ready)
        cmd(1, $urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom_range(0, 7)),
            {$urandom, $urandom}, 8'($urandom));
      dif.r0_rsp_ready = $urandom_range(0, 99) < 75;
      dif.r1_rsp_ready = $urandom_range(0, 99) < 75;
      @(negedge clk);
      if ((dif.r0_cmd_valid || dif.r1_cmd_valid) && !(dif.r0_cmd_ready || dif.r1_cmd_ready))
        stall++;
      else
        stall = 0;
      if (stall > max_stall) max_stall = stall;
      nxt();
    end
    check("rand_progress", max_stall <= 40, 1);
    cmd(0, 0, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 0, 0);
    dif.r0_rsp_ready = 1'b1;
    dif.r1_rsp_ready = 1'b1;
    repeat (2) nxt();

    // Reset while a response is outstanding.
    cmd(0, 1, 1, 5, 0, 0);
    dif.r0_rsp_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = dif.r0_cmd_ready;
      nxt();
    end
    check("mid_grant", got, 1);
    @(negedge clk);
    check("mid_rsp", dif.r0_rsp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_grant", dif.r0_cmd_ready, 1);
    nxt();
    cmd(0, 0, 0, 0, 0, 0);
    dif.r0_rsp_ready = 1'b1;
    @(negedge clk);
    check("post_reset_rsp", dif.r0_rsp_valid, 1);
    nxt();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
